// File: rtl/scan_cut_pkg.sv
// Shared constants for the scan-inserted CUT: chain length, I/O widths and
// the three state taps folded into each primary output.
package scan_cut_pkg;
  localparam int unsigned N_CELLS = 227;
  localparam int unsigned N_PI    = 35;
  localparam int unsigned N_PO    = 49;

  localparam int unsigned TAP0 = 0;
  localparam int unsigned TAP1 = 49;
  localparam int unsigned TAP2 = 98;
endpackage

// File: rtl/scan_cell.sv
// Mux-D scan flip-flop: se selects the serial input over the functional d.
module scan_cell (
  input  logic clk,
  input  logic rst,
  input  logic se,
  input  logic si,
  input  logic d,
  output logic q
);
  always_ff @(posedge clk) begin
    if (rst)     q <= 1'b0;
    else if (se) q <= si;
    else         q <= d;
  end
endmodule

// File: rtl/scan_cut.sv
// Scan-inserted sequential CUT: 227 cells on one chain, nonlinear capture
// function over 35 gated primary inputs, Moore XOR-folded outputs.
module scan_cut
  import scan_cut_pkg::*;
(
  input  logic bistmode,
  input  logic scanmode,
  input  logic sdi,
  output logic sdo,
  input  logic clk,
  input  logic rst,
  input  logic pi0,  pi1,  pi2,  pi3,  pi4,  pi5,  pi6,  pi7,  pi8,  pi9,
  input  logic pi10, pi11, pi12, pi13, pi14, pi15, pi16, pi17, pi18, pi19,
  input  logic pi20, pi21, pi22, pi23, pi24, pi25, pi26, pi27, pi28, pi29,
  input  logic pi30, pi31, pi32, pi33, pi34,
  output logic po0,  po1,  po2,  po3,  po4,  po5,  po6,  po7,  po8,  po9,
  output logic po10, po11, po12, po13, po14, po15, po16, po17, po18, po19,
  output logic po20, po21, po22, po23, po24, po25, po26, po27, po28, po29,
  output logic po30, po31, po32, po33, po34, po35, po36, po37, po38, po39,
  output logic po40, po41, po42, po43, po44, po45, po46, po47, po48
);
  logic [N_PI-1:0]    p_raw;
  logic [N_PI-1:0]    p;
  logic [N_CELLS-1:0] s;
  logic [N_CELLS-1:0] d;
  logic [N_PO-1:0]    po_vec;

  assign p_raw = {pi34, pi33, pi32, pi31, pi30, pi29, pi28, pi27, pi26, pi25,
                  pi24, pi23, pi22, pi21, pi20, pi19, pi18, pi17, pi16, pi15,
                  pi14, pi13, pi12, pi11, pi10, pi9,  pi8,  pi7,  pi6,  pi5,
                  pi4,  pi3,  pi2,  pi1,  pi0};

  // BIST isolation only touches the capture path; shift and decode ignore it.
  assign p = bistmode ? '0 : p_raw;

  for (genvar i = 0; i < N_CELLS; i++) begin : g_cell
    localparam int unsigned PREV = (i + N_CELLS - 1) % N_CELLS;
    localparam int unsigned NXT1 = (i + 1) % N_CELLS;
    localparam int unsigned NXT2 = (i + 2) % N_CELLS;
    localparam int unsigned PIDX = i % N_PI;

    logic si;
    if (i == 0) begin : g_head
      assign si = sdi;
    end else begin : g_body
      assign si = s[PREV];
    end

    assign d[i] = s[PREV] ^ (s[NXT1] & s[NXT2]) ^ p[PIDX];

    scan_cell u_cell (
      .clk (clk),
      .rst (rst),
      .se  (scanmode),
      .si  (si),
      .d   (d[i]),
      .q   (s[i])
    );
  end

  for (genvar j = 0; j < N_PO; j++) begin : g_po
    assign po_vec[j] = s[j + TAP0] ^ s[j + TAP1] ^ s[j + TAP2];
  end

  assign sdo = s[N_CELLS-1];

  assign {po48, po47, po46, po45, po44, po43, po42, po41, po40, po39,
          po38, po37, po36, po35, po34, po33, po32, po31, po30, po29,
          po28, po27, po26, po25, po24, po23, po22, po21, po20, po19,
          po18, po17, po16, po15, po14, po13, po12, po11, po10, po9,
          po8,  po7,  po6,  po5,  po4,  po3,  po2,  po1,  po0} = po_vec;
endmodule

// File: tb/tb_scan_cut.sv
// Self-checking bench for scan_cut: constant vector table, scoreboarded
// reference model on every edge, and serial unload checks of corner cases.
module tb_scan_cut;
  logic        clk = 1'b0;
  logic        rst, bistmode, scanmode, sdi;
  logic        sdo;
  logic [34:0] pi;
  logic [48:0] po;

  int checks = 0;
  int errors = 0;
  int stepn  = 0;

  logic [226:0] m;         // reference state
  logic [49:0]  sb_q[$];   // expected {sdo, po} per edge

  always #5 clk = ~clk;

  scan_cut dut (
    .bistmode(bistmode), .scanmode(scanmode), .sdi(sdi), .sdo(sdo),
    .clk(clk), .rst(rst),
    .pi0(pi[0]),   .pi1(pi[1]),   .pi2(pi[2]),   .pi3(pi[3]),   .pi4(pi[4]),
    .pi5(pi[5]),   .pi6(pi[6]),   .pi7(pi[7]),   .pi8(pi[8]),   .pi9(pi[9]),
    .pi10(pi[10]), .pi11(pi[11]), .pi12(pi[12]), .pi13(pi[13]), .pi14(pi[14]),
    .pi15(pi[15]), .pi16(pi[16]), .pi17(pi[17]), .pi18(pi[18]), .pi19(pi[19]),
    .pi20(pi[20]), .pi21(pi[21]), .pi22(pi[22]), .pi23(pi[23]), .pi24(pi[24]),
    .pi25(pi[25]), .pi26(pi[26]), .pi27(pi[27]), .pi28(pi[28]), .pi29(pi[29]),
    .pi30(pi[30]), .pi31(pi[31]), .pi32(pi[32]), .pi33(pi[33]), .pi34(pi[34]),
    .po0(po[0]),   .po1(po[1]),   .po2(po[2]),   .po3(po[3]),   .po4(po[4]),
    .po5(po[5]),   .po6(po[6]),   .po7(po[7]),   .po8(po[8]),   .po9(po[9]),
    .po10(po[10]), .po11(po[11]), .po12(po[12]), .po13(po[13]), .po14(po[14]),
    .po15(po[15]), .po16(po[16]), .po17(po[17]), .po18(po[18]), .po19(po[19]),
    .po20(po[20]), .po21(po[21]), .po22(po[22]), .po23(po[23]), .po24(po[24]),
    .po25(po[25]), .po26(po[26]), .po27(po[27]), .po28(po[28]), .po29(po[29]),
    .po30(po[30]), .po31(po[31]), .po32(po[32]), .po33(po[33]), .po34(po[34]),
    .po35(po[35]), .po36(po[36]), .po37(po[37]), .po38(po[38]), .po39(po[39]),
    .po40(po[40]), .po41(po[41]), .po42(po[42]), .po43(po[43]), .po44(po[44]),
    .po45(po[45]), .po46(po[46]), .po47(po[47]), .po48(po[48])
  );

  typedef struct {
    logic        r, sm, bm, sd;
    logic [34:0] piv;
    logic        exp_sdo;
    logic [48:0] exp_po;
  } vec_t;

  vec_t tbl[8];

  function automatic logic [34:0] rand_pi();
    logic [63:0] w;
    w = {$urandom(), $urandom()};
    return w[34:0];
  endfunction

  // Drive one edge, advance the reference model, scoreboard the result.
  task automatic step(input logic r, input logic sm, input logic sd,
                      input logic bm, input logic [34:0] piv);
    logic [226:0] nm;
    logic [34:0]  pe;
    logic [48:0]  epo;
    logic [49:0]  exp_v;
    rst = r; scanmode = sm; sdi = sd; bistmode = bm; pi = piv;
    pe = bm ? 35'd0 : piv;
    if (r) nm = '0;
    else if (sm) nm = {m[225:0], sd};
    else
      for (int i = 0; i < 227; i++)
        nm[i] = m[(i + 226) % 227] ^ (m[(i + 1) % 227] & m[(i + 2) % 227]) ^ pe[i % 35];
    m = nm;
    for (int j = 0; j < 49; j++) epo[j] = m[j] ^ m[j + 49] ^ m[j + 98];
    sb_q.push_back({m[226], epo});
    @(posedge clk);
    #1;
    stepn++;
    exp_v = sb_q.pop_front();
    checks++;
    if ({sdo, po} !== exp_v) begin
      errors++;
      $display("FAIL sb step=%0d got sdo=%b po=%h exp sdo=%b po=%h",
               stepn, sdo, po, exp_v[49], exp_v[48:0]);
    end
  endtask

  // Serially read all 227 cells; sample k is cell 226-k.
  task automatic unload(output logic [226:0] got);
    for (int k = 0; k < 227; k++) begin
      got[226 - k] = sdo;
      step(1'b0, 1'b1, 1'b0, 1'b0, rand_pi());
    end
  endtask

  task automatic load_bits(input logic [226:0] v);
    for (int t = 0; t < 227; t++) step(1'b0, 1'b1, v[226 - t], 1'b0, rand_pi());
  endtask

  task automatic chk_vec(input string name, input logic [226:0] got,
                         input logic [226:0] exp_v);
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp_v);
    end
  endtask

  initial begin
    logic [226:0] got, exp_v;
    int first_one;

    rst = 1'b1; scanmode = 1'b1; sdi = 1'b0; bistmode = 1'b0; pi = '0;
    m = '0;

    tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b1, rand_pi(), 1'b0, 49'd0};
    tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 35'd1,     1'b0, 49'h408_0020_0081};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b0, rand_pi(), 1'b0, 49'd0};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 35'd1,     1'b0, 49'd0};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b0, '1,        1'b0, 49'd0};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b0, '1,        1'b1, '1};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b0, '1,        1'b1, '1};
    tbl[7] = '{1'b1, 1'b1, 1'b0, 1'b1, '1,        1'b0, 49'd0};

    for (int unsigned t = 0; t < 8; t++) begin
      step(tbl[t].r, tbl[t].sm, tbl[t].sd, tbl[t].bm, tbl[t].piv);
      checks++;
      if (sdo !== tbl[t].exp_sdo || po !== tbl[t].exp_po) begin
        errors++;
        $display("FAIL tbl[%0d] got sdo=%b po=%h exp sdo=%b po=%h",
                 t, sdo, po, tbl[t].exp_sdo, tbl[t].exp_po);
      end
    end

    // Single 1 travels the whole chain: first visible after edge 227.
    step(1'b0, 1'b1, 1'b1, 1'b0, rand_pi());
    first_one = (sdo === 1'b1) ? 1 : 0;
    for (int e = 2; e <= 240 && first_one == 0; e++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, rand_pi());
      if (sdo === 1'b1) first_one = e;
    end
    checks++;
    if (first_one != 227) begin
      errors++;
      $display("FAIL shift_latency got=%0d exp=227", first_one);
    end
    step(1'b0, 1'b1, 1'b0, 1'b0, rand_pi());
    checks++;
    if (sdo !== 1'b0) begin
      errors++;
      $display("FAIL shift_after got=%b exp=0", sdo);
    end

    // Capture with pi0 only, then unload.
    step(1'b1, 1'b1, 1'b0, 1'b0, rand_pi());
    step(1'b0, 1'b0, 1'b0, 1'b0, 35'd1);
    unload(got);
    exp_v = '0;
    for (int k = 0; k < 227; k += 35) exp_v[k] = 1'b1;
    chk_vec("capture_unload", got, exp_v);

    // Nonlinear term: cells 1 and 2 set, capture with P = 0.
    step(1'b1, 1'b1, 1'b0, 1'b0, rand_pi());
    exp_v = '0; exp_v[1] = 1'b1; exp_v[2] = 1'b1;
    load_bits(exp_v);
    step(1'b0, 1'b0, 1'b0, 1'b1, rand_pi());
    unload(got);
    exp_v = '0; exp_v[0] = 1'b1; exp_v[2] = 1'b1; exp_v[3] = 1'b1;
    chk_vec("nonlinear_unload", got, exp_v);

    // Reset mid-load clears the chain.
    for (int t = 0; t < 100; t++) step(1'b0, 1'b1, 1'b1, 1'b0, rand_pi());
    step(1'b1, 1'b1, 1'b1, 1'b0, rand_pi());
    unload(got);
    chk_vec("reset_mid_shift", got, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
